// File: rtl/serial_frame_tx_arbiter.sv
// serial_frame_tx_arbiter: shares one serial line among four requesters with round-robin
// arbitration. Each frame is a start bit, a 2-bit port, a 4-bit length, L payload bits and
// GAP_BITS idle-high bits. All sequencing advances only on clk_en bit ticks.
module serial_frame_tx_arbiter #(
    parameter int unsigned GAP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [3:0]  req,
    input  logic [15:0] len,
    input  logic [59:0] data,
    output logic        ser_out,
    output logic [3:0]  ack,
    output logic        busy,
    output logic        done
);
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned DATA_W  = 15;
    localparam int unsigned HDR_W   = 6;
    localparam int unsigned GAP_W   = 3;
    // Gap counter load value: counts down to zero across the gap bits.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS == 0) ? 0 : (GAP_BITS - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PORT,
        S_LEN,
        S_DATA,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          fcnt_q, fcnt_d;   // bit position within PORT/LEN/DATA
    logic [GAP_W-1:0]    gcnt_q, gcnt_d;   // remaining gap bits
    logic [HDR_W-1:0]    hdr_q, hdr_d;     // {port, len} header, shifted out MSB first
    logic [DATA_W-1:0]   sh_q, sh_d;       // payload, left-aligned so data[L-1] leaves first
    logic [LEN_W-1:0]    len_q, len_d;
    logic [1:0]          last_q, last_d;   // round-robin pointer
    logic                ser_q, ser_d;
    logic [3:0]          ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                win_found;
    logic [1:0]          win_idx;
    logic [1:0]          cand;
    logic [3:0]          len_base;
    logic [5:0]          data_base;
    logic [LEN_W-1:0]    win_len;
    logic [DATA_W-1:0]   win_data;
    logic                end_payload;

    assign ser_out = ser_q;
    assign ack     = ack_q;
    assign busy    = busy_q;
    assign done    = done_q;

    // Round-robin winner: first set request scanning upward from last+1, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = last_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        len_base  = {win_idx, 2'b00};
        data_base = 6'(DATA_W) * 6'(win_idx);
        win_len   = len[len_base +: LEN_W];
        win_data  = data[data_base +: DATA_W];
    end

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        gcnt_d      = gcnt_q;
        hdr_d       = hdr_q;
        sh_d        = sh_q;
        len_d       = len_q;
        last_d      = last_q;
        ser_d       = ser_q;
        ack_d       = 4'b0000;
        busy_d      = busy_q;
        done_d      = 1'b0;
        end_payload = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clk_en && win_found) begin
                    state_d = S_START;
                    hdr_d   = {win_idx, win_len};
                    len_d   = win_len;
                    sh_d    = win_data << (4'(DATA_W) - win_len);
                    last_d  = win_idx;
                    ack_d   = 4'b0001 << win_idx;
                    ser_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (clk_en) begin
                    state_d = S_PORT;
                    fcnt_d  = 4'd1;
                    ser_d   = hdr_q[HDR_W-1];
                    hdr_d   = hdr_q << 1;
                end
            end
            S_PORT: begin
                if (clk_en) begin
                    ser_d = hdr_q[HDR_W-1];
                    hdr_d = hdr_q << 1;
                    if (fcnt_q == 4'd0) begin
                        state_d = S_LEN;
                        fcnt_d  = 4'd3;
                    end else begin
                        fcnt_d = fcnt_q - 4'd1;
                    end
                end
            end
            S_LEN: begin
                if (clk_en) begin
                    if (fcnt_q != 4'd0) begin
                        ser_d  = hdr_q[HDR_W-1];
                        hdr_d  = hdr_q << 1;
                        fcnt_d = fcnt_q - 4'd1;
                    end else if (len_q != 4'd0) begin
                        state_d = S_DATA;
                        fcnt_d  = len_q - 4'd1;
                        ser_d   = sh_q[DATA_W-1];
                        sh_d    = sh_q << 1;
                    end else begin
                        end_payload = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (clk_en) begin
                    if (fcnt_q != 4'd0) begin
                        ser_d  = sh_q[DATA_W-1];
                        sh_d   = sh_q << 1;
                        fcnt_d = fcnt_q - 4'd1;
                    end else begin
                        end_payload = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (clk_en) begin
                    if (gcnt_q == 3'd0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        gcnt_d = gcnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ser_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Leaving the last payload bit: pulse done, then gap or straight back to idle.
        if (end_payload) begin
            done_d = 1'b1;
            ser_d  = 1'b1;
            if (GAP_BITS != 0) begin
                state_d = S_GAP;
                gcnt_d  = GAP_LAST;
            end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= 4'd0;
            gcnt_q  <= 3'd0;
            hdr_q   <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            last_q  <= 2'd3;
            ser_q   <= 1'b1;
            ack_q   <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            gcnt_q  <= gcnt_d;
            hdr_q   <= hdr_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            last_q  <= last_d;
            ser_q   <= ser_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
